// File: rtl/soc_mem_bist_master_pkg.sv
// Shared encodings and helpers for the memory BIST master and its bus access engine.
package soc_mem_bist_master_pkg;

    localparam logic [3:0] SEL_ALL = 4'hF;
    localparam int         TO_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WGAP,
        ST_RD,
        ST_RGAP,
        ST_DONE
    } bist_state_t;

    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_BUSY,
        ACC_RGAP
    } acc_state_t;

    // Test word for a given byte address.
    function automatic logic [31:0] bist_pattern(input logic [31:0] addr, input logic [31:0] seed);
        return addr ^ seed;
    endfunction

endpackage

// File: rtl/soc_wb_single_access.sv
// Issues one Wishbone access, holds cyc/stb until termination, reissues after rty and
// enforces the retry limit and the no-response timeout.
module soc_wb_single_access
    import soc_mem_bist_master_pkg::*;
#(
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        launch,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [31:0] req_data,
    input  logic        ack,
    input  logic        err,
    input  logic        rty,
    output logic        cyc,
    output logic        stb,
    output logic        we,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    output logic        ok,
    output logic        fail
);

    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    acc_state_t        state_reg;
    logic              cyc_reg;
    logic              we_reg;
    logic [31:0]       addr_reg;
    logic [31:0]       wdata_reg;
    logic [RTY_W-1:0]  rty_cnt_reg;
    logic [TO_W-1:0]   to_cnt_reg;

    logic in_access;
    logic term_err;
    logic term_rty;
    logic retry_over;
    logic timeout_hit;

    // Terminations are only honoured while the strobe is out; err beats rty beats ack.
    assign in_access   = (state_reg == ACC_BUSY);
    assign term_err    = in_access && err;
    assign term_rty    = in_access && !err && rty;
    assign retry_over  = term_rty && (rty_cnt_reg == RTY_W'(MAX_RETRY));
    assign timeout_hit = in_access && !err && !rty && !ack && (to_cnt_reg == TO_W'(TIMEOUT - 1));

    assign ok    = in_access && !err && !rty && ack;
    assign fail  = term_err || retry_over || timeout_hit;

    assign cyc   = cyc_reg;
    assign stb   = cyc_reg;
    assign we    = we_reg;
    assign addr  = addr_reg;
    assign wdata = wdata_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ACC_IDLE;
            cyc_reg     <= 1'b0;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            rty_cnt_reg <= '0;
            to_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                ACC_IDLE: begin
                    if (launch) begin
                        state_reg   <= ACC_BUSY;
                        cyc_reg     <= 1'b1;
                        we_reg      <= req_we;
                        addr_reg    <= req_addr;
                        wdata_reg   <= req_data;
                        rty_cnt_reg <= '0;
                        to_cnt_reg  <= '0;
                    end
                end
                ACC_BUSY: begin
                    if (ok || fail) begin
                        state_reg <= ACC_IDLE;
                        cyc_reg   <= 1'b0;
                    end else if (term_rty) begin
                        state_reg   <= ACC_RGAP;
                        cyc_reg     <= 1'b0;
                        rty_cnt_reg <= rty_cnt_reg + 1'b1;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end
                ACC_RGAP: begin
                    // One idle cycle after rty, then the identical access goes out again.
                    state_reg  <= ACC_BUSY;
                    cyc_reg    <= 1'b1;
                    to_cnt_reg <= '0;
                end
                default: begin
                    state_reg <= ACC_IDLE;
                    cyc_reg   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/soc_mem_bist_master.sv
// Wishbone BIST initiator: writes an address-derived pattern over a memory range, reads it
// back, and reports pass/abort, first failing address/data and a saturating mismatch count.
module soc_mem_bist_master
    import soc_mem_bist_master_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          NUM_WORDS = 16,
    parameter logic [31:0] SEED      = 32'hA5A5_5A5A,
    parameter int          MAX_RETRY = 3,
    parameter int          TIMEOUT   = 255,
    localparam int         IDXW      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic          mem_clk_i,
    input  logic          mem_rst_i,
    input  logic          start_i,
    input  logic [31:0]   mem_data_i,
    output logic [31:0]   mem_data_o,
    output logic [31:0]   mem_addr_o,
    output logic [3:0]    mem_sel_o,
    output logic          mem_we_o,
    output logic          mem_cyc_o,
    output logic          mem_stb_o,
    input  logic          mem_ack_i,
    input  logic          mem_err_i,
    input  logic          mem_rty_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          pass_o,
    output logic          abort_o,
    output logic [31:0]   fail_addr_o,
    output logic [31:0]   fail_data_o,
    output logic [IDXW:0] err_cnt_o
);

    bist_state_t     state_reg;
    logic [IDXW-1:0] idx_reg;
    logic            busy_reg;
    logic            done_reg;
    logic            pass_reg;
    logic            abort_reg;
    logic [31:0]     fail_addr_reg;
    logic [31:0]     fail_data_reg;
    logic [IDXW:0]   err_cnt_reg;

    logic            launch;
    logic [IDXW-1:0] req_idx;
    logic            req_we;
    logic [31:0]     req_addr;
    logic [31:0]     req_data;
    logic            acc_ok;
    logic            acc_fail;
    logic [31:0]     acc_addr;
    logic            last_idx;
    logic            mismatch;

    function automatic logic [31:0] word_addr(input logic [IDXW-1:0] i);
        return BASE_ADDR + (32'(i) << 2);
    endfunction

    assign last_idx = (idx_reg == IDXW'(NUM_WORDS - 1));
    assign req_addr = word_addr(req_idx);
    assign req_data = req_we ? bist_pattern(req_addr, SEED) : 32'h0;
    assign mismatch = (mem_data_i != bist_pattern(acc_addr, SEED));

    // The next access is launched on the same edge the FSM leaves IDLE/DONE or a gap state,
    // so a zero-wait responder costs exactly access + gap per word.
    always_comb begin
        launch  = 1'b0;
        req_idx = idx_reg + IDXW'(1);
        req_we  = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                launch  = start_i;
                req_idx = '0;
                req_we  = 1'b1;
            end
            ST_WGAP: begin
                launch  = 1'b1;
                req_idx = last_idx ? '0 : idx_reg + IDXW'(1);
                req_we  = !last_idx;
            end
            ST_RGAP: begin
                launch = !last_idx;
            end
            default: ;
        endcase
    end

    soc_wb_single_access #(
        .MAX_RETRY (MAX_RETRY),
        .TIMEOUT   (TIMEOUT)
    ) u_access (
        .clk      (mem_clk_i),
        .rst_n    (mem_rst_i),
        .launch   (launch),
        .req_addr (req_addr),
        .req_we   (req_we),
        .req_data (req_data),
        .ack      (mem_ack_i),
        .err      (mem_err_i),
        .rty      (mem_rty_i),
        .cyc      (mem_cyc_o),
        .stb      (mem_stb_o),
        .we       (mem_we_o),
        .addr     (acc_addr),
        .wdata    (mem_data_o),
        .ok       (acc_ok),
        .fail     (acc_fail)
    );

    assign mem_addr_o  = acc_addr;
    assign mem_sel_o   = mem_stb_o ? SEL_ALL : 4'h0;
    assign busy_o      = busy_reg;
    assign done_o      = done_reg;
    assign pass_o      = pass_reg;
    assign abort_o     = abort_reg;
    assign fail_addr_o = fail_addr_reg;
    assign fail_data_o = fail_data_reg;
    assign err_cnt_o   = err_cnt_reg;

    always_ff @(posedge mem_clk_i) begin
        if (!mem_rst_i) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            pass_reg      <= 1'b0;
            abort_reg     <= 1'b0;
            fail_addr_reg <= '0;
            fail_data_reg <= '0;
            err_cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_reg     <= ST_WR;
                        idx_reg       <= '0;
                        busy_reg      <= 1'b1;
                        done_reg      <= 1'b0;
                        pass_reg      <= 1'b0;
                        abort_reg     <= 1'b0;
                        fail_addr_reg <= '0;
                        fail_data_reg <= '0;
                        err_cnt_reg   <= '0;
                    end
                end
                ST_WR, ST_RD: begin
                    if (acc_fail) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        pass_reg  <= 1'b0;
                        abort_reg <= 1'b1;
                        // An earlier mismatch keeps its place as the first failure.
                        if (err_cnt_reg == '0) begin
                            fail_addr_reg <= acc_addr;
                        end
                    end else if (acc_ok) begin
                        if (state_reg == ST_RD && mismatch) begin
                            if (err_cnt_reg != '1) begin
                                err_cnt_reg <= err_cnt_reg + 1'b1;
                            end
                            if (err_cnt_reg == '0) begin
                                fail_addr_reg <= acc_addr;
                                fail_data_reg <= mem_data_i;
                            end
                        end
                        state_reg <= (state_reg == ST_WR) ? ST_WGAP : ST_RGAP;
                    end
                end
                ST_WGAP: begin
                    idx_reg   <= req_idx;
                    state_reg <= last_idx ? ST_RD : ST_WR;
                end
                ST_RGAP: begin
                    if (last_idx) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        pass_reg  <= (err_cnt_reg == '0) && !abort_reg;
                    end else begin
                        idx_reg   <= req_idx;
                        state_reg <= ST_RD;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_soc_mem_bist_master.sv
// Table-driven bench for soc_mem_bist_master with a configurable echo/constant/silent responder.
module tb_soc_mem_bist_master;

    localparam logic [31:0] SEED = 32'hA5A5_5A5A;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  sel;
    logic        we, cyc, stb, ack, err, rty;
    logic        busy, done, pass, abort;
    logic [31:0] fail_addr, fail_data;
    logic [4:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    // responder configuration: mode 0 echo RAM, 1 constant data, 2 never answers
    int          mode = 0;
    int          rty_limit = 0;
    bit          err_en = 1'b0;
    int          inj_word = 0;
    bit          inj_we = 1'b0;
    int          rty_seen = 0;
    int          issue_cnt = 0;
    logic [31:0] ram [0:15];
    logic        hit, err_cond, rty_cond;

    typedef struct {
        int          mode;
        int          rty_limit;
        bit          err_en;
        int          inj_word;
        bit          inj_we;
        bit          mid_start;
        int          exp_cycles;
        bit          exp_pass;
        bit          exp_abort;
        int          exp_cnt;
        logic [31:0] exp_fa;
        logic [31:0] exp_fd;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    soc_mem_bist_master dut (
        .mem_clk_i   (clk),
        .mem_rst_i   (rst_n),
        .start_i     (start),
        .mem_data_i  (mem_data_i),
        .mem_data_o  (mem_data_o),
        .mem_addr_o  (mem_addr_o),
        .mem_sel_o   (sel),
        .mem_we_o    (we),
        .mem_cyc_o   (cyc),
        .mem_stb_o   (stb),
        .mem_ack_i   (ack),
        .mem_err_i   (err),
        .mem_rty_i   (rty),
        .busy_o      (busy),
        .done_o      (done),
        .pass_o      (pass),
        .abort_o     (abort),
        .fail_addr_o (fail_addr),
        .fail_data_o (fail_data),
        .err_cnt_o   (err_cnt)
    );

    // Injected err/rty come together with ack so termination priority is exercised too.
    always_comb begin
        hit        = cyc && stb && (mem_addr_o[5:2] == 4'(inj_word)) && (we == inj_we);
        err_cond   = err_en && hit;
        rty_cond   = hit && (rty_seen < rty_limit);
        err        = err_cond;
        rty        = err_cond || rty_cond;
        ack        = cyc && stb && (mode != 2);
        mem_data_i = (mode == 1) ? 32'h1BAD_C0DE : ram[mem_addr_o[5:2]];
    end

    always @(posedge clk) begin
        if (start) begin
            rty_seen  <= 0;
            issue_cnt <= 0;
        end else begin
            if (rty_cond) rty_seen <= rty_seen + 1;
            if (cyc && stb && (ack || err || rty) && we && mem_addr_o == 32'd20)
                issue_cnt <= issue_cnt + 1;
        end
        if (cyc && stb && ack && !err && !rty && we)
            ram[mem_addr_o[5:2]] <= mem_data_o;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int cycles;
        mode      = v.mode;
        rty_limit = v.rty_limit;
        err_en    = v.err_en;
        inj_word  = v.inj_word;
        inj_we    = v.inj_we;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; cycles = 1;
        while (!done && cycles < 400) begin
            @(negedge clk);
            cycles++;
            start = v.mid_start && (cycles == 20);
        end
        start = 1'b0;
        $display("run %0d: cycles=%0d pass=%0b abort=%0b err_cnt=%0d fail_addr=%08h fail_data=%08h",
                 n, cycles, pass, abort, err_cnt, fail_addr, fail_data);
        check($sformatf("v%0d_cycles", n), 32'(cycles), 32'(v.exp_cycles));
        check($sformatf("v%0d_pass", n), 32'(pass), 32'(v.exp_pass));
        check($sformatf("v%0d_abort", n), 32'(abort), 32'(v.exp_abort));
        check($sformatf("v%0d_err_cnt", n), 32'(err_cnt), 32'(v.exp_cnt));
        check($sformatf("v%0d_fail_addr", n), fail_addr, v.exp_fa);
        check($sformatf("v%0d_fail_data", n), fail_data, v.exp_fd);
        check($sformatf("v%0d_busy", n), 32'(busy), 32'd0);
        check($sformatf("v%0d_cyc", n), 32'(cyc), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        //          mode rty err word we mid cyc  pass abort cnt fail_addr      fail_data
        vecs[0] = '{0, 0, 1'b0, 0, 1'b0, 1'b1,  65, 1'b1, 1'b0,  0, 32'd0,  32'h0};
        vecs[1] = '{1, 0, 1'b0, 0, 1'b0, 1'b0,  65, 1'b0, 1'b0, 16, 32'd0,  32'h1BAD_C0DE};
        vecs[2] = '{0, 2, 1'b0, 5, 1'b1, 1'b0,  69, 1'b1, 1'b0,  0, 32'd0,  32'h0};
        vecs[3] = '{0, 4, 1'b0, 5, 1'b1, 1'b0,  18, 1'b0, 1'b1,  0, 32'd20, 32'h0};
        vecs[4] = '{0, 0, 1'b1, 3, 1'b0, 1'b0,  40, 1'b0, 1'b1,  0, 32'd12, 32'h0};
        vecs[5] = '{2, 0, 1'b0, 0, 1'b0, 1'b0, 256, 1'b0, 1'b1,  0, 32'd0,  32'h0};
        vecs[6] = '{0, 0, 1'b0, 0, 1'b0, 1'b0,  65, 1'b1, 1'b0,  0, 32'd0,  32'h0};

        repeat (3) @(negedge clk);
        $display("reset: busy=%0b done=%0b cyc=%0b err_cnt=%0d", busy, done, cyc, err_cnt);
        check("rst_status", {27'd0, busy, done, pass, abort, cyc}, 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
            if (i == 0) begin
                check("ram0", ram[0], 32'hA5A5_5A5A);
                for (int k = 0; k < 16; k++)
                    check($sformatf("ram%0d", k), ram[k], (32'(k) << 2) ^ SEED);
            end
            if (i == 2) begin
                $display("run 2: word 5 write issued %0d times", issue_cnt);
                check("rty_issue_cnt", 32'(issue_cnt), 32'd3);
            end
        end

        // Reset while a read is on the bus.
        mode = 0; rty_limit = 0; err_en = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!(cyc && !we) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach_read", 32'(cyc && !we), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        $display("mid-read reset: busy=%0b cyc=%0b stb=%0b addr=%08h", busy, cyc, stb, mem_addr_o);
        check("mrst_ctrl", {21'd0, busy, done, pass, abort, cyc, stb, we, sel}, 32'd0);
        check("mrst_addr", mem_addr_o, 32'd0);
        check("mrst_wdata", mem_data_o, 32'd0);
        check("mrst_fail", fail_addr | fail_data | 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", {30'd0, busy, cyc}, 32'd0);
        run_vec(7, vecs[6]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
